clut_write_ctrl: RTL

Write-port controller for the colour lookup table. It shares the CLUT's single write port between two sources: a host that writes one palette entry at a time, and a bulk loader that streams a whole palette from a ROM. Writes happen only during display blanking so that no visible pixel sees a half-updated palette. It sits between the host/register interface and the CLUT write port (`we`, `cidx_write`, `colr_in`), in the CLUT write-clock domain.

---
 rtl/clut_pkg.sv | 17 +
 rtl/clut_fade.sv | 25 ++
 rtl/clut_write_ctrl.sv | 120 ++++++++++++
 3 files changed

// File: rtl/clut_pkg.sv
// clut_pkg: state encoding and channel geometry shared by the CLUT write-port controller.
`default_nettype none

package clut_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    DRAIN = 2'd2
  } clut_wr_state_t;

  localparam int CHANW = 4;
  localparam int NCHAN = 3;

endpackage

`default_nettype wire

// File: rtl/clut_fade.sv
// clut_fade: combinational 3-channel brightness scaler, each channel becomes (c*(level+1))>>4.
`default_nettype none

module clut_fade
  import clut_pkg::*;
(
  input  logic [NCHAN*CHANW-1:0] i_colr,
  input  logic [CHANW-1:0]       i_level,
  output logic [NCHAN*CHANW-1:0] o_colr
);

  logic [2*CHANW-1:0] w_lvl1;

  assign w_lvl1 = {{CHANW{1'b0}}, i_level} + (2*CHANW)'(1);

  for (genvar ch = 0; ch < NCHAN; ch++) begin : g_chan
    logic [2*CHANW-1:0] w_chan;
    assign w_chan = {{CHANW{1'b0}}, i_colr[ch*CHANW +: CHANW]};
    // 15*16 fits in 2*CHANW bits, so the shifted product never overflows a channel
    assign o_colr[ch*CHANW +: CHANW] = CHANW'((w_chan * w_lvl1) >> CHANW);
  end

endmodule

`default_nettype wire

// File: rtl/clut_write_ctrl.sv
// clut_write_ctrl: arbitrates host and ROM bulk-load writes onto the CLUT write port during blanking.
// Optional feature macro: CLUT_FADE_EN (adds fade_level and the clut_fade colour scaler).
`default_nettype none

module clut_write_ctrl
  import clut_pkg::*;
#(
  parameter int COLRW = 12,
  parameter int CIDXW = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             blank,
  input  logic             host_valid,
  output logic             host_ready,
  input  logic [CIDXW-1:0] host_idx,
  input  logic [COLRW-1:0] host_colr,
  input  logic             load_start,
  output logic             load_busy,
  output logic             load_done,
  output logic [CIDXW-1:0] rom_addr,
  input  logic [COLRW-1:0] rom_data,
`ifdef CLUT_FADE_EN
  input  logic [3:0]       fade_level,
`endif
  output logic             we,
  output logic [CIDXW-1:0] cidx_write,
  output logic [COLRW-1:0] colr_in
);

  clut_wr_state_t   r_state;
  logic [CIDXW-1:0] r_cnt;
  logic             r_iss_v;
  logic             r_iss_last;
  logic [CIDXW-1:0] r_iss_idx;
  logic             r_we;
  logic [CIDXW-1:0] r_cidx;
  logic [COLRW-1:0] r_colr;
  logic             r_load_done;

  logic             w_host_fire;
  logic             w_wr;
  logic [COLRW-1:0] w_colr_sel;
  logic [COLRW-1:0] w_colr_out;

  // rst gating keeps the handshake closed while the block is held in reset
  assign host_ready  = blank && (r_state == IDLE) && !load_start && !rst;
  assign w_host_fire = host_valid && host_ready;
  assign w_wr        = w_host_fire || r_iss_v;
  assign w_colr_sel  = w_host_fire ? host_colr : rom_data;

`ifdef CLUT_FADE_EN
  clut_fade u_fade (
    .i_colr  (w_colr_sel),
    .i_level (fade_level),
    .o_colr  (w_colr_out)
  );
`else
  assign w_colr_out = w_colr_sel;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_iss_v     <= 1'b0;
      r_iss_last  <= 1'b0;
      r_iss_idx   <= '0;
      r_we        <= 1'b0;
      r_cidx      <= '0;
      r_colr      <= '0;
      r_load_done <= 1'b0;
    end else begin
      r_iss_v     <= 1'b0;
      r_iss_last  <= 1'b0;
      r_we        <= w_wr;
      r_load_done <= r_iss_v && r_iss_last;
      if (w_wr) begin
        r_cidx <= w_host_fire ? host_idx : r_iss_idx;
        r_colr <= w_colr_out;
      end
      case (r_state)
        IDLE: begin
          if (load_start) begin
            r_state <= LOAD;
            r_cnt   <= '0;
          end
        end
        LOAD: begin
          // issued addresses always complete; ROM data arrives one cycle after issue
          if (blank) begin
            r_iss_v    <= 1'b1;
            r_iss_idx  <= r_cnt;
            r_iss_last <= (r_cnt == {CIDXW{1'b1}});
            r_cnt      <= r_cnt + 1'b1;
            if (r_cnt == {CIDXW{1'b1}}) begin
              r_state <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (r_load_done) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign rom_addr   = r_cnt;
  assign load_busy  = (r_state != IDLE);
  assign load_done  = r_load_done;
  assign we         = r_we;
  assign cidx_write = r_cidx;
  assign colr_in    = r_colr;

endmodule

`default_nettype wire
